// File: rtl/t07_mem_sequencer.sv
// Load/store sequencer between the t07 core and the MMIO bus: alternates fetch and data phases.
// Build option T07_MISALIGN_SPLIT_EN turns misaligned accesses into two bus beats instead of a fault.
module t07_mem_sequencer #(
    parameter int NSRC    = 2,
    parameter int TIMEOUT = 255,
    localparam int SEL_W  = (NSRC > 1) ? $clog2(NSRC) : 1
) (
    input  logic               clk,
    input  logic               nrst,
    input  logic               busy,
    input  logic [3:0]         mem_op,
    input  logic               mem_read,
    input  logic               mem_write,
    input  logic [SEL_W-1:0]   src_sel,
    input  logic [NSRC*32-1:0] src_data,
    input  logic [31:0]        alu_addr,
    input  logic [31:0]        bus_rdata,
    output logic [31:0]        bus_addr,
    output logic [31:0]        bus_wdata,
    output logic [3:0]         bus_be,
    output logic [1:0]         rwi,
    output logic               addr_ctrl,
    output logic               freeze,
    output logic [31:0]        reg_wdata,
    output logic               reg_we,
    output logic               fault,
    output logic [2:0]         state
);

    localparam logic [2:0] S_FETCH = 3'd0;
    localparam logic [2:0] S_FWAIT = 3'd1;
    localparam logic [2:0] S_DATA  = 3'd2;
    localparam logic [2:0] S_DWAIT = 3'd3;
    localparam logic [2:0] S_SPLIT = 3'd4;
    localparam logic [2:0] S_SWAIT = 3'd5;

    logic        prev_busy;
    logic        done;
    logic [2:0]  state_nx;
    logic        fault_nx;
    logic        load_done;
    logic        in_wait;
    logic        timed_out;
    logic [31:0] cnt;

    logic [3:0]  mask_in;
    logic        sgn_in;
    logic        op_ok;
    logic [1:0]  off_in;
    logic        mis_in;
    logic        req;
    logic        reject;
    logic [31:0] sel_data;
    logic [7:0]  be8_in;

    logic [29:0] c_word;
    logic [1:0]  c_off;
    logic [3:0]  c_mask;
    logic        c_sgn;
    logic        c_write;
    logic        c_split;
    logic [31:0] c_src;
    logic [31:0] c_lo;
    logic [7:0]  c_be8;
    logic [4:0]  sh1;
    logic [5:0]  sh2;
    logic [31:0] ld_raw;

    assign done = ~busy & prev_busy;

    always_comb begin
        mask_in = '0;
        sgn_in  = 1'b0;
        op_ok   = 1'b1;
        case (mem_op)
            4'd1:       begin mask_in = 4'h1; sgn_in = 1'b1; end
            4'd2:       begin mask_in = 4'h3; sgn_in = 1'b1; end
            4'd3, 4'd8: mask_in = 4'hF;
            4'd4, 4'd6: mask_in = 4'h1;
            4'd5, 4'd7: mask_in = 4'h3;
            default:    op_ok = 1'b0;
        endcase
    end

    assign off_in = alu_addr[1:0];
    assign mis_in = (mask_in == 4'h3 && off_in == 2'd3) || (mask_in == 4'hF && off_in != 2'd0);
    assign req    = op_ok & (mem_write | mem_read);
    assign be8_in = {4'b0000, mask_in} << off_in;

`ifdef T07_MISALIGN_SPLIT_EN
    assign reject = 1'b0;
`else
    assign reject = mis_in;
`endif

    always_comb begin
        sel_data = '0;
        for (int unsigned i = 0; i < NSRC; i++)
            if (src_sel == SEL_W'(i)) sel_data = src_data[32*i +: 32];
    end

    // Beat 2 carries the lanes that overflowed past the word boundary in beat 1.
    assign c_be8  = {4'b0000, c_mask} << c_off;
    assign sh1    = {c_off, 3'b000};
    assign sh2    = 6'd32 - {1'b0, c_off, 3'b000};
    assign ld_raw = (state == S_SWAIT) ? (c_lo | (bus_rdata << sh2)) : (bus_rdata >> sh1);

    function automatic logic [31:0] extend(input logic [31:0] v, input logic [3:0] mask,
                                           input logic sgn);
        logic [31:0] r;
        case (mask)
            4'h1:    r = {{24{sgn & v[7]}}, v[7:0]};
            4'h3:    r = {{16{sgn & v[15]}}, v[15:0]};
            default: r = v;
        endcase
        return r;
    endfunction

    assign in_wait   = (state == S_FWAIT) || (state == S_DWAIT) || (state == S_SWAIT);
    assign timed_out = (TIMEOUT != 0) && !done && (cnt >= 32'(TIMEOUT - 1));

    always_comb begin
        state_nx  = state;
        fault_nx  = 1'b0;
        load_done = 1'b0;
        case (state)
            S_FETCH: state_nx = S_FWAIT;
            S_FWAIT: begin
                if (done) state_nx = S_DATA;
                else if (timed_out) begin state_nx = S_FETCH; fault_nx = 1'b1; end
            end
            S_DATA: begin
                if (req && !reject) state_nx = S_DWAIT;
                else begin
                    state_nx = S_FETCH;
                    fault_nx = req & reject;
                end
            end
            S_DWAIT: begin
                if (done) begin
                    if (c_split) state_nx = S_SPLIT;
                    else begin state_nx = S_FETCH; load_done = ~c_write; end
                end else if (timed_out) begin
                    state_nx = S_FETCH;
                    fault_nx = 1'b1;
                end
            end
            S_SPLIT: state_nx = S_SWAIT;
            S_SWAIT: begin
                if (done) begin state_nx = S_FETCH; load_done = ~c_write; end
                else if (timed_out) begin state_nx = S_FETCH; fault_nx = 1'b1; end
            end
            default: state_nx = S_FETCH;
        endcase
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state     <= S_FETCH;
            prev_busy <= 1'b0;
            cnt       <= '0;
            fault     <= 1'b0;
            reg_we    <= 1'b0;
            reg_wdata <= '0;
            c_word    <= '0;
            c_off     <= '0;
            c_mask    <= '0;
            c_sgn     <= 1'b0;
            c_write   <= 1'b0;
            c_split   <= 1'b0;
            c_src     <= '0;
            c_lo      <= '0;
        end else begin
            prev_busy <= busy;
            state     <= state_nx;
            fault     <= fault_nx;
            reg_we    <= load_done;
            if (load_done) reg_wdata <= extend(ld_raw, c_mask, c_sgn);
            if (state_nx != state) cnt <= '0;
            else if (in_wait)      cnt <= cnt + 32'd1;
            if (state == S_DATA) begin
                c_word  <= alu_addr[31:2];
                c_off   <= off_in;
                c_mask  <= mask_in;
                c_sgn   <= sgn_in;
                c_write <= mem_write;
                c_split <= mis_in;
                c_src   <= sel_data;
            end
            if (state == S_DWAIT && done) c_lo <= bus_rdata >> sh1;
        end
    end

    always_comb begin
        rwi       = 2'b11;
        addr_ctrl = 1'b1;
        freeze    = 1'b0;
        bus_be    = 4'hF;
        bus_addr  = '0;
        bus_wdata = '0;
        case (state)
            S_FWAIT: freeze = 1'b1;
            S_DATA: begin
                addr_ctrl = 1'b0;
                rwi       = 2'b00;
                bus_be    = 4'h0;
                if (req && !reject) begin
                    rwi      = mem_write ? 2'b01 : 2'b10;
                    freeze   = 1'b1;
                    bus_addr = {alu_addr[31:2], 2'b00};
                    bus_be   = be8_in[3:0];
                    if (mem_write) bus_wdata = sel_data << {off_in, 3'b000};
                end
            end
            S_DWAIT: begin
                addr_ctrl = 1'b0;
                rwi       = c_write ? 2'b01 : 2'b10;
                freeze    = 1'b1;
                bus_addr  = {c_word, 2'b00};
                bus_be    = c_be8[3:0];
                if (c_write) bus_wdata = c_src << sh1;
            end
            S_SPLIT, S_SWAIT: begin
                addr_ctrl = 1'b0;
                rwi       = c_write ? 2'b01 : 2'b10;
                freeze    = 1'b1;
                bus_addr  = {c_word, 2'b00} + 32'd4;
                bus_be    = c_be8[7:4];
                if (c_write) bus_wdata = c_src >> sh2;
            end
            default: ;
        endcase
    end

endmodule
